// File: rtl/bram_readback_checker_if.sv
// Port-B read bus between the readback checker (master) and the BRAM (slave).
// The checker drives enable/address; the RAM returns data RD_LAT cycles later.
interface bram_rd_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;

    modport master (output enb, output addrb, input doutb);
    modport slave  (input enb, input addrb, output doutb);
endinterface

// File: rtl/bram_readback_checker.sv
// Sweeps BRAM port B over 0..DEPTH-1, tracks read latency and checks each word
// against (addr + PATTERN_BASE), reporting pass, error count and first bad address.
//
// state   | meaning
// S_IDLE  | waiting for start; results from the last sweep held
// S_READ  | one read issued per cycle, addrb 0..DEPTH-1
// S_DRAIN | no reads; RD_LAT cycles for the final words to return
// S_DONE  | one-cycle done pulse, pass valid
module bram_readback_checker #(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 16,
    parameter int                DEPTH        = 1024,
    parameter int                RD_LAT       = 1,
    parameter logic [DATA_W-1:0] PATTERN_BASE = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    bram_rd_if.master         bram,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LOAD = 2'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_enb;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_drain_cnt;
    logic [RD_LAT-1:0]   r_pipe_vld;
    logic [ADDR_W-1:0]   r_pipe_addr [RD_LAT];
    logic [ADDR_W:0]     r_err_cnt;
    logic [ADDR_W:0]     w_err_nxt;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_pass;
    logic                w_tail_vld;
    logic [ADDR_W-1:0]   w_tail_addr;
    logic [DATA_W-1:0]   w_expected;
    logic                w_mismatch;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_enb       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_enb = 1'b1;
                if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == 2'd0) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tail of the latency pipe lines up with the cycle in which doutb is valid.
    assign w_tail_vld  = r_pipe_vld[RD_LAT-1];
    assign w_tail_addr = r_pipe_addr[RD_LAT-1];
    assign w_expected  = DATA_W'(w_tail_addr) + PATTERN_BASE;
    assign w_mismatch  = w_tail_vld && (bram.doutb != w_expected);
    assign w_err_nxt   = r_err_cnt + (ADDR_W+1)'(w_mismatch);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr           <= '0;
            r_drain_cnt      <= '0;
            r_pipe_vld       <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_addr[i] <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
        end else begin
            r_pipe_vld[0]  <= w_enb;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end

            if (r_state == S_READ)                            r_drain_cnt <= DRAIN_LOAD;
            else if (r_state == S_DRAIN && r_drain_cnt != 2'd0) r_drain_cnt <= r_drain_cnt - 2'd1;

            if (w_accept) begin
                r_addr           <= '0;
                r_err_cnt        <= '0;
                r_first_err_addr <= '0;
                r_pass           <= 1'b0;
            end else begin
                // Address holds at DEPTH-1 through DRAIN and IDLE.
                if (r_state == S_READ && r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
                if (w_mismatch) begin
                    r_err_cnt <= w_err_nxt;
                    if (r_err_cnt == '0) r_first_err_addr <= w_tail_addr;
                end
                // Last compare lands on the same edge that enters DONE.
                if (r_state == S_DRAIN && w_state_nxt == S_DONE) r_pass <= (w_err_nxt == '0);
            end
        end
    end

    assign bram.enb         = w_enb;
    assign bram.addrb       = r_addr;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = (r_state == S_DONE);
    assign o_pass           = r_pass;
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_bram_readback_checker.sv
// Directed bench for bram_readback_checker: four instances cover RD_LAT 1/2,
// a pattern offset, DEPTH=1 and the full 1024-word sweep.
module tb_bram_readback_checker;

    logic clk;
    logic rst;
    logic [3:0] start_v;
    int n_cmp;
    int n_err;
    int sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bram_rd_if #(.ADDR_W(4),  .DATA_W(16)) if0 ();
    bram_rd_if #(.ADDR_W(4),  .DATA_W(16)) if1 ();
    bram_rd_if #(.ADDR_W(10), .DATA_W(16)) if2 ();
    bram_rd_if #(.ADDR_W(4),  .DATA_W(16)) if3 ();

    logic [3:0] busy_v, done_v, pass_v;
    logic [4:0]  err0, err1, err3;
    logic [10:0] err2;
    logic [3:0]  fea0, fea1, fea3;
    logic [9:0]  fea2;

    bram_readback_checker #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .RD_LAT(1), .PATTERN_BASE(16'h0000)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .bram(if0),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]), .o_err_cnt(err0), .o_first_err_addr(fea0));
    bram_readback_checker #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .RD_LAT(2), .PATTERN_BASE(16'h1000)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .bram(if1),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]), .o_err_cnt(err1), .o_first_err_addr(fea1));
    bram_readback_checker #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .RD_LAT(1), .PATTERN_BASE(16'h0000)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .bram(if2),
        .o_busy(busy_v[2]), .o_done(done_v[2]), .o_pass(pass_v[2]), .o_err_cnt(err2), .o_first_err_addr(fea2));
    bram_readback_checker #(.ADDR_W(4), .DATA_W(16), .DEPTH(1), .RD_LAT(2), .PATTERN_BASE(16'h00AB)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[3]), .bram(if3),
        .o_busy(busy_v[3]), .o_done(done_v[3]), .o_pass(pass_v[3]), .o_err_cnt(err3), .o_first_err_addr(fea3));

    // RAM models with the matching read latency
    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    logic [15:0] mem2 [1024];
    logic [15:0] mem3 [1];
    logic [15:0] r1_stage, r3_stage;

    always @(posedge clk) if (if0.enb) if0.doutb <= mem0[if0.addrb];
    always @(posedge clk) begin
        if (if1.enb) r1_stage <= mem1[if1.addrb];
        if1.doutb <= r1_stage;
    end
    always @(posedge clk) if (if2.enb) if2.doutb <= mem2[if2.addrb];
    always @(posedge clk) begin
        if (if3.enb) r3_stage <= mem3[0];
        if3.doutb <= r3_stage;
    end

    logic        m_enb, m_busy, m_done, m_pass;
    logic [10:0] m_addr, m_err;
    logic [9:0]  m_fea;

    always_comb begin
        m_enb = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        m_addr = '0; m_err = '0; m_fea = '0;
        case (sel)
            0: begin m_enb = if0.enb; m_addr = 11'(if0.addrb); m_busy = busy_v[0]; m_done = done_v[0];
                     m_pass = pass_v[0]; m_err = 11'(err0); m_fea = 10'(fea0); end
            1: begin m_enb = if1.enb; m_addr = 11'(if1.addrb); m_busy = busy_v[1]; m_done = done_v[1];
                     m_pass = pass_v[1]; m_err = 11'(err1); m_fea = 10'(fea1); end
            2: begin m_enb = if2.enb; m_addr = 11'(if2.addrb); m_busy = busy_v[2]; m_done = done_v[2];
                     m_pass = pass_v[2]; m_err = err2; m_fea = fea2; end
            3: begin m_enb = if3.enb; m_addr = 11'(if3.addrb); m_busy = busy_v[3]; m_done = done_v[3];
                     m_pass = pass_v[3]; m_err = 11'(err3); m_fea = 10'(fea3); end
            default: ;
        endcase
    end

    // Runs one sweep on instance `which`, sampling at negedges; cycle 1 follows the accept edge.
    task automatic sweep(input int which, input int budget, input int restart_at, input bit restart_in_done,
                         output int n_enb, output int n_done, output int done_cyc, output bit addr_ok,
                         output bit pass_c1, output int err_c1);
        n_enb = 0; n_done = 0; done_cyc = -1; addr_ok = 1'b1; pass_c1 = 1'b0; err_c1 = 0;
        sel = which;
        @(negedge clk); start_v[which] = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin pass_c1 = m_pass; err_c1 = int'(m_err); end
            if (m_enb) begin
                if (int'(m_addr) != n_enb) addr_ok = 1'b0;
                n_enb++;
            end
            start_v[which] = 1'b0;
            if (m_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                if (restart_in_done) start_v[which] = 1'b1;
            end
            if (cyc == restart_at) start_v[which] = 1'b1;
        end
        start_v[which] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            sel = w; #1;
            n_cmp++; if ({m_enb, m_busy, m_done, m_pass} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl dut%0d: got enb/busy/done/pass=%b required 0000", w, {m_enb, m_busy, m_done, m_pass}); end
            n_cmp++; if (m_addr !== 11'd0 || m_err !== 11'd0 || m_fea !== 10'd0) begin n_err++; $display("FAIL reset_regs dut%0d: got addrb=%0d err=%0d fea=%0d required 0/0/0", w, m_addr, m_err, m_fea); end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_sweep_lat1();
        int ne, nd, dc, e1; bit ok, p1;
        for (int a = 0; a < 16; a++) mem0[a] = 16'(a);
        sweep(0, 40, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 16 || !ok) begin n_err++; $display("FAIL lat1_reads: got %0d reads addr_ok=%0d required 16 reads 0..15", ne, ok); end
        n_cmp++; if (dc !== 18 || nd !== 1) begin n_err++; $display("FAIL lat1_done: got cycle %0d count %0d required cycle 18 count 1", dc, nd); end
        n_cmp++; if (m_pass !== 1'b1 || m_err !== 11'd0 || m_fea !== 10'd0 || m_busy !== 1'b0) begin n_err++; $display("FAIL lat1_result: got pass=%0d err=%0d fea=%0d busy=%0d required 1/0/0/0", m_pass, m_err, m_fea, m_busy); end
    endtask

    task automatic test_sweep_lat2();
        int ne, nd, dc, e1; bit ok, p1;
        for (int a = 0; a < 16; a++) mem1[a] = 16'(a) + 16'h1000;
        sweep(1, 40, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 16 || !ok) begin n_err++; $display("FAIL lat2_reads: got %0d reads addr_ok=%0d required 16", ne, ok); end
        n_cmp++; if (dc !== 19 || nd !== 1) begin n_err++; $display("FAIL lat2_done: got cycle %0d count %0d required cycle 19 count 1", dc, nd); end
        n_cmp++; if (m_pass !== 1'b1 || m_err !== 11'd0) begin n_err++; $display("FAIL lat2_result: got pass=%0d err=%0d required 1/0", m_pass, m_err); end
    endtask

    task automatic test_errors();
        int ne, nd, dc, e1; bit ok, p1;
        mem0[5] = 16'hFFFF; mem0[11] = 16'hFFFF;
        sweep(0, 40, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (m_pass !== 1'b0 || m_err !== 11'd2 || m_fea !== 10'd5) begin n_err++; $display("FAIL err_result: got pass=%0d err=%0d fea=%0d required 0/2/5", m_pass, m_err, m_fea); end
        repeat (6) @(negedge clk);
        n_cmp++; if (m_pass !== 1'b0 || m_err !== 11'd2 || m_fea !== 10'd5) begin n_err++; $display("FAIL err_hold: got pass=%0d err=%0d fea=%0d required 0/2/5", m_pass, m_err, m_fea); end
        mem0[5] = 16'd5; mem0[11] = 16'd11;
        sweep(0, 40, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (p1 !== 1'b0 || e1 !== 0) begin n_err++; $display("FAIL err_clear_on_start: got pass=%0d err=%0d required 0/0", p1, e1); end
        n_cmp++; if (m_pass !== 1'b1 || m_err !== 11'd0 || m_fea !== 10'd0) begin n_err++; $display("FAIL err_repaired: got pass=%0d err=%0d fea=%0d required 1/0/0", m_pass, m_err, m_fea); end
    endtask

    task automatic test_restart_ignored();
        int ne, nd, dc, e1; bit ok, p1;
        sweep(0, 40, 7, 1'b1, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 16 || !ok) begin n_err++; $display("FAIL restart_reads: got %0d reads addr_ok=%0d required 16", ne, ok); end
        n_cmp++; if (nd !== 1 || dc !== 18) begin n_err++; $display("FAIL restart_done: got count %0d cycle %0d required 1 at 18", nd, dc); end
    endtask

    task automatic test_reset_mid();
        int ne, nd, dc, e1; bit ok, p1;
        int pre_enb; int late_done; bit err_seen;
        sel = 0; pre_enb = 0; late_done = 0; err_seen = 1'b0;
        mem0[8] = 16'hFFFF;
        @(negedge clk); start_v[0] = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk); start_v[0] = 1'b0;
            if (m_enb) pre_enb++;
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if (pre_enb !== 9) begin n_err++; $display("FAIL rstmid_pre_reads: got %0d required 9", pre_enb); end
        n_cmp++; if ({m_enb, m_busy, m_done, m_pass} !== 4'b0000) begin n_err++; $display("FAIL rstmid_after: got enb/busy/done/pass=%b required 0000", {m_enb, m_busy, m_done, m_pass}); end
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (m_done) late_done++;
            if (m_err != 11'd0) err_seen = 1'b1;
        end
        n_cmp++; if (late_done !== 0 || err_seen) begin n_err++; $display("FAIL rstmid_quiet: got %0d done pulses err_seen=%0d required 0/0", late_done, err_seen); end
        mem0[8] = 16'd8;
        sweep(0, 40, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 16 || dc !== 18 || m_pass !== 1'b1 || m_err !== 11'd0) begin n_err++; $display("FAIL rstmid_resweep: got reads=%0d done=%0d pass=%0d err=%0d required 16/18/1/0", ne, dc, m_pass, m_err); end
    endtask

    task automatic test_back_to_back();
        int ne, d1, d2, nd, tail_done;
        sel = 0; ne = 0; d1 = 0; d2 = 0; nd = 0; tail_done = 0;
        @(negedge clk); start_v[0] = 1'b1;
        for (int cyc = 1; cyc <= 38; cyc++) begin
            @(negedge clk);
            if (m_enb) ne++;
            if (m_done) begin
                nd++;
                if (d1 == 0) d1 = cyc; else if (d2 == 0) d2 = cyc;
            end
        end
        start_v[0] = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (m_done) tail_done++;
        end
        n_cmp++; if (d1 !== 18 || d2 !== 37 || nd !== 2) begin n_err++; $display("FAIL b2b_done: got cycles %0d,%0d count %0d required 18,37 count 2", d1, d2, nd); end
        n_cmp++; if (ne !== 32) begin n_err++; $display("FAIL b2b_reads: got %0d required 32", ne); end
        n_cmp++; if (tail_done !== 0 || m_busy !== 1'b0 || m_pass !== 1'b1) begin n_err++; $display("FAIL b2b_tail: got extra done=%0d busy=%0d pass=%0d required 0/0/1", tail_done, m_busy, m_pass); end
    endtask

    task automatic test_depth1();
        int ne, nd, dc, e1; bit ok, p1;
        mem3[0] = 16'h00AB;
        sweep(3, 20, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 1 || !ok || dc !== 4 || m_pass !== 1'b1) begin n_err++; $display("FAIL depth1_ok: got reads=%0d addr_ok=%0d done=%0d pass=%0d required 1/1/4/1", ne, ok, dc, m_pass); end
        mem3[0] = 16'h0000;
        sweep(3, 20, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (m_pass !== 1'b0 || m_err !== 11'd1 || m_fea !== 10'd0 || m_addr !== 11'd0) begin n_err++; $display("FAIL depth1_bad: got pass=%0d err=%0d fea=%0d addrb=%0d required 0/1/0/0", m_pass, m_err, m_fea, m_addr); end
    endtask

    task automatic test_full();
        int ne, nd, dc, e1; bit ok, p1;
        for (int a = 0; a < 1024; a++) mem2[a] = 16'(a);
        sweep(2, 1060, -1, 1'b0, ne, nd, dc, ok, p1, e1);
        n_cmp++; if (ne !== 1024 || !ok) begin n_err++; $display("FAIL full_reads: got %0d addr_ok=%0d required 1024", ne, ok); end
        n_cmp++; if (dc !== 1026 || nd !== 1) begin n_err++; $display("FAIL full_done: got cycle %0d count %0d required 1026 count 1", dc, nd); end
        n_cmp++; if (m_pass !== 1'b1 || m_err !== 11'd0 || m_addr !== 11'd1023) begin n_err++; $display("FAIL full_result: got pass=%0d err=%0d addrb=%0d required 1/0/1023", m_pass, m_err, m_addr); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; sel = 0;
        rst = 1'b1; start_v = '0;
        test_reset();
        test_sweep_lat1();
        test_sweep_lat2();
        test_errors();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_depth1();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
